// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - byte delivery and status bundle for uart_rx
interface uart_rx_if;
    logic [7:0] byte_received;
    logic       valid;
    logic       ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output byte_received, valid, framing_error, overrun,
        input  ready
    );

    modport slave (
        input  byte_received, valid, framing_error, overrun,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, majority-voted mid-bit sampling, one-entry holding register
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master data
);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(MID);
    localparam logic [CW-1:0] CNT_S2   = CW'(MID + 1);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic          rx_meta, rx_sync;
    logic [CW-1:0] clk_count, clk_count_d;
    logic [2:0]    bit_index, bit_index_d;
    logic [7:0]    shift_reg, shift_d;
    logic          samp0, samp1, samp0_d, samp1_d;
    logic          majority, byte_done, stop_bad;
    logic [7:0]    byte_q;
    logic          valid_q, ferr_q, ovr_q;

    assign majority = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_comb begin
        state_d     = state;
        clk_count_d = clk_count;
        bit_index_d = bit_index;
        shift_d     = shift_reg;
        samp0_d     = (clk_count == CNT_S0) ? rx_sync : samp0;
        samp1_d     = (clk_count == CNT_S1) ? rx_sync : samp1;
        byte_done   = 1'b0;
        stop_bad    = 1'b0;
        case (state)
            // Require a full bit time of continuous high before trusting a falling edge.
            WAIT_IDLE: begin
                if (!rx_sync) begin
                    clk_count_d = '0;
                end else if (clk_count == CNT_LAST) begin
                    clk_count_d = '0;
                    state_d     = IDLE;
                end else begin
                    clk_count_d = clk_count + CW'(1);
                end
            end
            IDLE: begin
                clk_count_d = '0;
                if (!rx_sync) state_d = START;
            end
            START: begin
                if (clk_count == CNT_S2 && majority) begin
                    clk_count_d = '0;
                    state_d     = IDLE;
                end else if (clk_count == CNT_LAST) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    state_d     = DATA;
                end else begin
                    clk_count_d = clk_count + CW'(1);
                end
            end
            DATA: begin
                if (clk_count == CNT_S2) shift_d = {majority, shift_reg[7:1]};
                if (clk_count == CNT_LAST) begin
                    clk_count_d = '0;
                    if (bit_index == 3'd7) state_d = STOP;
                    else                   bit_index_d = bit_index + 3'd1;
                end else begin
                    clk_count_d = clk_count + CW'(1);
                end
            end
            // Leave at mid stop bit so the next start edge can arrive early.
            STOP: begin
                if (clk_count == CNT_S2) begin
                    clk_count_d = '0;
                    if (majority) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end else begin
                    clk_count_d = clk_count + CW'(1);
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAIT_IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            samp0     <= 1'b0;
            samp1     <= 1'b0;
        end else begin
            state     <= state_d;
            clk_count <= clk_count_d;
            bit_index <= bit_index_d;
            shift_reg <= shift_d;
            samp0     <= samp0_d;
            samp1     <= samp1_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= stop_bad;
            ovr_q  <= 1'b0;
            if (byte_done) begin
                if (!valid_q || data.ready) begin
                    byte_q  <= shift_reg;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && data.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data.byte_received = byte_q;
    assign data.valid         = valid_q;
    assign data.framing_error = ferr_q;
    assign data.overrun       = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized scoreboard bench for uart_rx
module tb_uart_rx;
    localparam int CPB = 104;

    logic clock = 1'b0;
    logic reset;
    logic rx;
    uart_rx_if bus();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .data  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rises = 0, rise_cyc = 0, hi_cyc = 0, fe_cnt = 0, ov_cnt = 0, hs_cnt = 0;
    int frame_start = 0;
    logic valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val);
        rx = 1'b0;
        frame_start = cyc + 1;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_val;
        tick(stop_len);
    endtask

    always @(negedge clock) begin
        cyc++;
        if (bus.framing_error) fe_cnt++;
        if (bus.overrun) ov_cnt++;
        if (bus.valid) hi_cyc++;
        if (bus.valid && !valid_prev) begin
            rises++;
            rise_cyc = cyc;
        end
        valid_prev = bus.valid;
        if (bus.valid && bus.ready) begin
            hs_cnt++;
            check("byte_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("byte_value", bus.byte_received, exp_q.pop_front());
        end
    end

    initial begin
        logic [7:0] b;
        int r0, h0, f0, o0, s0, lat;

        reset = 1'b1;
        rx = 1'b1;
        bus.ready = 1'b0;
        tick(3);
        check("rst_byte", bus.byte_received, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_ferr", bus.framing_error, 0);
        check("rst_ovr", bus.overrun, 0);
        reset = 1'b0;
        tick(110);

        // Single frame, consumer always ready
        bus.ready = 1'b1;
        r0 = rises; h0 = hi_cyc; f0 = fe_cnt; o0 = ov_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, CPB, 1'b1);
        tick(20);
        lat = rise_cyc - frame_start;
        check("s1_valid_pulses", rises - r0, 1);
        check("s1_valid_width", hi_cyc - h0, 1);
        check("s1_latency_in_window", (lat >= 992 && lat <= 996), 1);
        check("s1_ferr", fe_cnt - f0, 0);
        check("s1_ovr", ov_cnt - o0, 0);

        // Two frames with consumer stalled: second byte dropped
        bus.ready = 1'b0;
        f0 = fe_cnt; o0 = ov_cnt; s0 = hs_cnt;
        send_frame(8'hA3, 60, 1'b1);
        send_frame(8'h00, 60, 1'b1);
        tick(10);
        check("s2_valid", bus.valid, 1);
        check("s2_byte_kept", bus.byte_received, 8'hA3);
        check("s2_ovr_pulses", ov_cnt - o0, 1);
        check("s2_ferr", fe_cnt - f0, 0);
        exp_q.push_back(8'hA3);
        bus.ready = 1'b1;
        tick(1);
        bus.ready = 1'b0;
        check("s2_valid_drop", bus.valid, 0);
        check("s2_handshakes", hs_cnt - s0, 1);

        // Consume on the exact completion cycle of the second frame
        tick(20);
        o0 = ov_cnt; s0 = hs_cnt;
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h00);
        fork
            begin
                send_frame(8'hA3, 60, 1'b1);
                send_frame(8'h00, 60, 1'b1);
            end
            begin
                tick(9 * CPB + 60 + 992);
                bus.ready = 1'b1;
                tick(1);
                bus.ready = 1'b0;
            end
        join
        tick(5);
        check("s3_valid", bus.valid, 1);
        check("s3_byte_new", bus.byte_received, 8'h00);
        check("s3_ovr", ov_cnt - o0, 0);
        check("s3_handshakes", hs_cnt - s0, 1);
        bus.ready = 1'b1;
        tick(2);
        check("s3_drained", bus.valid, 0);

        // Short low glitch on an idle line
        r0 = rises; f0 = fe_cnt;
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(200);
        check("s4_glitch_no_valid", rises - r0, 0);
        check("s4_glitch_no_ferr", fe_cnt - f0, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, CPB, 1'b1);
        tick(20);
        check("s4_after_glitch", rises - r0, 1);

        // Low stop bit then stuck-low line
        r0 = rises; f0 = fe_cnt;
        send_frame(8'hFF, CPB, 1'b0);
        tick(300);
        check("s5_ferr_pulses", fe_cnt - f0, 1);
        check("s5_no_valid", rises - r0, 0);
        rx = 1'b1;
        tick(CPB);
        exp_q.push_back(8'h81);
        send_frame(8'h81, CPB, 1'b1);
        tick(20);
        check("s5_recovered", rises - r0, 1);
        check("s5_ferr_total", fe_cnt - f0, 1);

        // Reset mid-frame with a held byte
        bus.ready = 1'b0;
        send_frame(8'h12, CPB, 1'b1);
        tick(20);
        check("s6_held_valid", bus.valid, 1);
        check("s6_held_byte", bus.byte_received, 8'h12);
        r0 = rises;
        b = {4'h0, 4'($urandom)};
        fork
            send_frame(b, CPB, 1'b1);
            begin
                tick(5 * CPB + CPB / 2);
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                check("s6_rst_valid", bus.valid, 0);
                check("s6_rst_byte", bus.byte_received, 0);
            end
        join
        tick(20);
        check("s6_partial_dropped", rises - r0, 0);
        bus.ready = 1'b1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, CPB, 1'b1);
        tick(20);
        check("s6_next_frame", rises - r0, 1);

        // Random bytes, random stop length and gaps
        r0 = rises; f0 = fe_cnt; o0 = ov_cnt;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, $urandom_range(60, CPB), 1'b1);
            tick($urandom_range(0, 20));
        end
        tick(30);
        check("rand_valid_count", rises - r0, 6);
        check("rand_ferr", fe_cnt - f0, 0);
        check("rand_ovr", ov_cnt - o0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
